// File: rtl/jump_pred_ctrl_pkg.sv
// rtl/jump_pred_ctrl_pkg.sv - shared types for the static jump prediction controller
package jump_pred_ctrl_pkg;

    localparam int INST_ADDR_BUS = 32;

    typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_JALR = 2'd1,
        ST_FLUSH     = 2'd2
    } state_e;

    // One in-flight prediction, oldest at the queue head.
    typedef struct packed {
        logic       is_jalr;
        logic       pred_taken;
        inst_addr_t pred_target;
        inst_addr_t fallthrough;
    } pred_entry_t;

    // Backward-taken / forward-not-taken: a negative offset means a loop back-edge.
    function automatic logic bxx_predict(input logic btfn_en, input logic imm_sign);
        return btfn_en & imm_sign;
    endfunction

endpackage

// File: rtl/jump_pred_ctrl_pred_fifo.sv
// rtl/jump_pred_ctrl_pred_fifo.sv - in-order queue of outstanding predictions
// Ports: clk, rst (sync, active-high); push/wdata enqueue; pop dequeues head (rdata);
//        clear empties the queue and wins over push; full/empty status.
module jump_pred_ctrl_pred_fifo
    import jump_pred_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t wdata,
    output pred_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    pred_entry_t mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // At full, a push is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~clear;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jump_pred_ctrl.sv
// rtl/jump_pred_ctrl.sv - static branch prediction, in-order verify and flush control
// Ports: clk, rst (sync, active-high); id_* / inst_* / jb_imm_i predecoded IF/ID inst;
//        hold_i pipeline hold; ex_* resolution of oldest control-flow inst;
//        pred_jump_o/pred_addr_o early redirect; fetch_stall_o; flush_o/flush_addr_o;
//        branch_cnt_o, mispred_cnt_o counters; err_o sticky resolve-on-empty.
module jump_pred_ctrl
    import jump_pred_ctrl_pkg::*;
#(
    parameter int PRED_DEPTH = 4,
    parameter bit BTFN_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic        inst_jal_i,
    input  logic        inst_jalr_i,
    input  logic        inst_bxx_i,
    input  logic [31:0] jb_imm_i,
    input  logic        hold_i,
    input  logic        ex_resolve_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    output logic        pred_jump_o,
    output logic [31:0] pred_addr_o,
    output logic        fetch_stall_o,
    output logic        flush_o,
    output logic [31:0] flush_addr_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o,
    output logic        err_o
);

    state_e      state_q;
    state_e      state_d;
    pred_entry_t head;
    pred_entry_t new_entry;
    inst_addr_t  pred_target;
    inst_addr_t  correct_addr;
    logic        pred_taken;
    logic        cf_new;
    logic        can_push;
    logic        push;
    logic        pop;
    logic        mispred;
    logic        redirect;
    logic        full;
    logic        empty;
    logic        flush_q;
    inst_addr_t  flush_addr_q;
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;
    logic        err_q;

    assign pred_target = id_pc_i + jb_imm_i;
    // jalr target is unknown here, so it is always predicted not taken.
    assign pred_taken  = ~inst_jalr_i &
                         (inst_jal_i | (inst_bxx_i & bxx_predict(BTFN_EN, jb_imm_i[31])));
    assign cf_new      = id_valid_i & (inst_jal_i | inst_jalr_i | inst_bxx_i) &
                         ~hold_i & (state_q == ST_RUN);

    assign pop          = ex_resolve_i & ~empty;
    assign mispred      = pop & ~head.is_jalr &
                          ((ex_taken_i != head.pred_taken) |
                           (ex_taken_i & (ex_target_i != head.pred_target)));
    assign redirect     = mispred | (pop & head.is_jalr);
    assign correct_addr = ex_taken_i ? ex_target_i : head.fallthrough;

    assign can_push = cf_new & (~full | pop);
    // A redirect kills everything younger, including the instruction in ID now.
    assign push     = can_push & ~redirect;

    assign new_entry = '{is_jalr:     inst_jalr_i,
                         pred_taken:  pred_taken,
                         pred_target: pred_target,
                         fallthrough: id_pc_i + 32'd4};

    jump_pred_ctrl_pred_fifo #(
        .DEPTH (PRED_DEPTH)
    ) u_pred_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata (new_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect)                 state_d = ST_FLUSH;
                else if (push && inst_jalr_i) state_d = ST_WAIT_JALR;
            end
            ST_WAIT_JALR: begin
                // Either the jalr resolves or an older mispredict discards it.
                if (redirect) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pred_jump_o   = ~rst & push & pred_taken;
        pred_addr_o   = rst ? 32'd0 : pred_target;
        fetch_stall_o = ~rst & ((state_q == ST_WAIT_JALR) | (cf_new & full & ~pop));
        flush_o       = ~rst & flush_q;
        flush_addr_o  = rst ? 32'd0 : flush_addr_q;
        branch_cnt_o  = rst ? 32'd0 : branch_cnt_q;
        mispred_cnt_o = rst ? 32'd0 : mispred_cnt_q;
        err_o         = ~rst & err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q       <= 1'b0;
            flush_addr_q  <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            flush_q <= redirect;
            if (redirect)             flush_addr_q  <= correct_addr;
            if (pop)                  branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispred)              mispred_cnt_q <= mispred_cnt_q + 32'd1;
            if (ex_resolve_i && empty) err_q        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jump_pred_ctrl.sv
// tb/tb_jump_pred_ctrl.sv - directed table-driven bench for jump_pred_ctrl
module tb_jump_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic        inst_jal_i;
    logic        inst_jalr_i;
    logic        inst_bxx_i;
    logic [31:0] jb_imm_i;
    logic        hold_i;
    logic        ex_resolve_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        pred_jump_o;
    logic [31:0] pred_addr_o;
    logic        fetch_stall_o;
    logic        flush_o;
    logic [31:0] flush_addr_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jump_pred_ctrl #(
        .PRED_DEPTH (4),
        .BTFN_EN    (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid_i),
        .id_pc_i       (id_pc_i),
        .inst_jal_i    (inst_jal_i),
        .inst_jalr_i   (inst_jalr_i),
        .inst_bxx_i    (inst_bxx_i),
        .jb_imm_i      (jb_imm_i),
        .hold_i        (hold_i),
        .ex_resolve_i  (ex_resolve_i),
        .ex_taken_i    (ex_taken_i),
        .ex_target_i   (ex_target_i),
        .pred_jump_o   (pred_jump_o),
        .pred_addr_o   (pred_addr_o),
        .fetch_stall_o (fetch_stall_o),
        .flush_o       (flush_o),
        .flush_addr_o  (flush_addr_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o),
        .err_o         (err_o)
    );

    // kind: 0 none, 1 jal, 2 jalr, 3 bxx
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        hold;
        logic        res;
        logic        tk;
        logic [31:0] tgt;
        logic        e_pj;
        logic [31:0] e_pa;
        logic        e_st;
        logic        e_fl;
        logic [31:0] e_fa;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int kind, logic [31:0] pc, logic [31:0] imm, logic hold,
                                logic res, logic tk, logic [31:0] tgt,
                                logic e_pj, logic [31:0] e_pa, logic e_st,
                                logic e_fl, logic [31:0] e_fa, logic [31:0] e_bc,
                                logic [31:0] e_mc, logic e_err);
        vec_t v;
        v.kind = kind; v.pc = pc; v.imm = imm; v.hold = hold;
        v.res = res; v.tk = tk; v.tgt = tgt;
        v.e_pj = e_pj; v.e_pa = e_pa; v.e_st = e_st;
        v.e_fl = e_fl; v.e_fa = e_fa; v.e_bc = e_bc; v.e_mc = e_mc; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [vec %0d]: got 0x%08h, want 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                         input logic hold, input logic res, input logic tk,
                         input logic [31:0] tgt);
        id_valid_i   = (kind != 0);
        inst_jal_i   = (kind == 1);
        inst_jalr_i  = (kind == 2);
        inst_bxx_i   = (kind == 3);
        id_pc_i      = pc;
        jb_imm_i     = imm;
        hold_i       = hold;
        ex_resolve_i = res;
        ex_taken_i   = tk;
        ex_target_i  = tgt;
    endtask

    task automatic chk_regs(input int idx, input logic fl, input logic [31:0] fa,
                            input logic [31:0] bc, input logic [31:0] mc, input logic er);
        chk("flush_o", idx, 32'(flush_o), 32'(fl));
        chk("flush_addr_o", idx, flush_addr_o, fa);
        chk("branch_cnt_o", idx, branch_cnt_o, bc);
        chk("mispred_cnt_o", idx, mispred_cnt_o, mc);
        chk("err_o", idx, 32'(err_o), 32'(er));
    endtask

    initial begin
        // Inputs applied 1 time unit after a rising edge; combinational outputs
        // checked 1 unit later; registered outputs checked 1 unit after the next edge.
        //        kind pc            imm           hd res tk tgt          pj pa            st fl fa            bc  mc er
        tbl.push_back(mk(1, 32'h100,  32'h40,       0, 0, 0, 32'h0,      1, 32'h140,      0, 0, 32'h0,     0,  0, 0));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h140,    0, 32'h0,        0, 0, 32'h0,     1,  0, 0));
        tbl.push_back(mk(3, 32'h200,  32'hFFFFFFF8, 0, 0, 0, 32'h0,      1, 32'h1F8,      0, 0, 32'h0,     1,  0, 0));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 32'h0,      0, 32'h0,        0, 1, 32'h204,   2,  1, 0));
        tbl.push_back(mk(1, 32'h400,  32'h10,       0, 0, 0, 32'h0,      0, 32'h410,      0, 0, 32'h204,   2,  1, 0));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h999,    0, 32'h0,        0, 0, 32'h204,   2,  1, 1));
        tbl.push_back(mk(2, 32'h300,  32'h0,        0, 0, 0, 32'h0,      0, 32'h300,      0, 0, 32'h204,   2,  1, 1));
        tbl.push_back(mk(1, 32'h600,  32'h4,        0, 0, 0, 32'h0,      0, 32'h604,      1, 0, 32'h204,   2,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h500,    0, 32'h0,        1, 1, 32'h500,   3,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 0, 0, 32'h0,      0, 32'h0,        0, 0, 32'h500,   3,  1, 1));
        tbl.push_back(mk(1, 32'h700,  32'h100,      0, 0, 0, 32'h0,      1, 32'h800,      0, 0, 32'h500,   3,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h800,    0, 32'h0,        0, 0, 32'h500,   4,  1, 1));
        tbl.push_back(mk(3, 32'h1000, 32'h20,       0, 0, 0, 32'h0,      0, 32'h1020,     0, 0, 32'h500,   4,  1, 1));
        tbl.push_back(mk(3, 32'h1004, 32'h20,       0, 0, 0, 32'h0,      0, 32'h1024,     0, 0, 32'h500,   4,  1, 1));
        tbl.push_back(mk(3, 32'h1008, 32'h20,       0, 0, 0, 32'h0,      0, 32'h1028,     0, 0, 32'h500,   4,  1, 1));
        tbl.push_back(mk(3, 32'h100C, 32'h20,       0, 0, 0, 32'h0,      0, 32'h102C,     0, 0, 32'h500,   4,  1, 1));
        tbl.push_back(mk(3, 32'h1010, 32'hFFFFFFF0, 0, 0, 0, 32'h0,      0, 32'h1000,     1, 0, 32'h500,   4,  1, 1));
        tbl.push_back(mk(3, 32'h1010, 32'hFFFFFFF0, 0, 1, 0, 32'h0,      1, 32'h1000,     0, 0, 32'h500,   5,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 32'h0,      0, 32'h0,        0, 0, 32'h500,   6,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 32'h0,      0, 32'h0,        0, 0, 32'h500,   7,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 32'h0,      0, 32'h0,        0, 0, 32'h500,   8,  1, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h1000,   0, 32'h0,        0, 0, 32'h500,   9,  1, 1));
        tbl.push_back(mk(3, 32'h2000, 32'h40,       0, 0, 0, 32'h0,      0, 32'h2040,     0, 0, 32'h500,   9,  1, 1));
        tbl.push_back(mk(3, 32'h2100, 32'h8,        0, 1, 1, 32'h2040,   0, 32'h2108,     0, 1, 32'h2040,  10, 2, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 0, 0, 32'h0,      0, 32'h0,        0, 0, 32'h2040,  10, 2, 1));
        tbl.push_back(mk(1, 32'h3000, 32'h10,       0, 0, 0, 32'h0,      1, 32'h3010,     0, 0, 32'h2040,  10, 2, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h3010,   0, 32'h0,        0, 0, 32'h2040,  11, 2, 1));
        tbl.push_back(mk(1, 32'h4000, 32'h8,        1, 0, 0, 32'h0,      0, 32'h4008,     0, 0, 32'h2040,  11, 2, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        0, 1, 1, 32'h4008,   0, 32'h0,        0, 0, 32'h2040,  11, 2, 1));
        tbl.push_back(mk(1, 32'h4000, 32'h8,        0, 0, 0, 32'h0,      1, 32'h4008,     0, 0, 32'h2040,  11, 2, 1));
        tbl.push_back(mk(0, 32'h0,    32'h0,        1, 1, 1, 32'h4008,   0, 32'h0,        0, 0, 32'h2040,  12, 2, 1));

        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_jump_o", -1, 32'(pred_jump_o), 32'h0);
        chk("rst_pred_addr_o", -1, pred_addr_o, 32'h0);
        chk("rst_fetch_stall_o", -1, 32'(fetch_stall_o), 32'h0);
        chk_regs(-1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].kind, tbl[i].pc, tbl[i].imm, tbl[i].hold,
                  tbl[i].res, tbl[i].tk, tbl[i].tgt);
            #1;
            chk("pred_jump_o", i, 32'(pred_jump_o), 32'(tbl[i].e_pj));
            chk("pred_addr_o", i, pred_addr_o, tbl[i].e_pa);
            chk("fetch_stall_o", i, 32'(fetch_stall_o), 32'(tbl[i].e_st));
            @(posedge clk);
            #1;
            chk_regs(i, tbl[i].e_fl, tbl[i].e_fa, tbl[i].e_bc, tbl[i].e_mc, tbl[i].e_err);
        end

        // Reset while waiting on a jalr: everything returns to idle, no flush.
        drive(2, 32'h5000, 32'h0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        #1;
        chk("wait_stall", 100, 32'(fetch_stall_o), 32'h1);
        rst = 1'b1;
        drive(1, 32'h6000, 32'h20, 0, 0, 0, 32'h0);
        #1;
        chk("rst_hi_pred_jump_o", 101, 32'(pred_jump_o), 32'h0);
        chk("rst_hi_stall", 101, 32'(fetch_stall_o), 32'h0);
        chk("rst_hi_pred_addr_o", 101, pred_addr_o, 32'h0);
        @(posedge clk);
        #1;
        chk_regs(101, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_pred_jump_o", 102, 32'(pred_jump_o), 32'h1);
        chk("post_rst_pred_addr_o", 102, pred_addr_o, 32'h6020);
        chk("post_rst_stall", 102, 32'(fetch_stall_o), 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_flush_o", 102, 32'(flush_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
